// File: rtl/pipe_trace_capture_if.sv
// Read-out beat stream of the retirement-trace capture block.
// The master drives beats; the slave (host reader) drives out_ready.
interface pipe_trace_capture_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/pipe_trace_capture.sv
// Retirement-trace capture: aligns pc/inst taps with their write-back result, buffers records
// in a FIFO and streams them as 32-bit beats. Define TRACE_REG28_EN for a fourth reg28 beat.
module pipe_trace_capture #(
    parameter int unsigned WB_LAG = 3,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_en,
    input  logic [31:0]             pc,
    input  logic [31:0]             inst,
    input  logic [31:0]             walu,
    input  logic [31:0]             reg28,
    pipe_trace_capture_if.master    bus,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             drop_cnt,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef TRACE_REG28_EN
    localparam int unsigned NBEATS = 4;
`else
    localparam int unsigned NBEATS = 3;
`endif
    localparam int unsigned RW = 32 * NBEATS;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } stage_t;

    stage_t          al [WB_LAG];
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      beat;

    logic [RW-1:0]   rec_c;
    logic [RW-1:0]   head_c;
    logic [31:0]     data_c;
    logic [AW-1:0]   rd_ptr_n_c;
    logic [1:0]      beat_n_c;
    logic            hs_c, pop_c, full_c, push_req_c, drop_c, push_c;

    // Record is packed so that beat k occupies bits [32k+31:32k].
`ifdef TRACE_REG28_EN
    assign rec_c = {reg28, walu, al[WB_LAG-1].inst, al[WB_LAG-1].pc};
`else
    assign rec_c = {walu, al[WB_LAG-1].inst, al[WB_LAG-1].pc};
    logic unused_reg28_c;
    assign unused_reg28_c = ^reg28;
`endif

    // Aligner: delays each sample until its write-back result is on walu.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WB_LAG); i++) al[i] <= '0;
        end else begin
            al[0] <= {cap_en, pc, inst};
            for (int i = 1; i < int'(WB_LAG); i++) al[i] <= al[i-1];
        end
    end

    always_comb begin
        hs_c       = bus.out_valid & bus.out_ready;
        pop_c      = hs_c & (beat == 2'(NBEATS - 1));
        full_c     = (fifo_count == CW'(DEPTH));
        push_req_c = al[WB_LAG-1].valid;
        drop_c     = push_req_c & full_c & ~pop_c;
        push_c     = push_req_c & ~drop_c;
        rd_ptr_n_c = pop_c ? rd_ptr + AW'(1) : rd_ptr;
        beat_n_c   = beat;
        if (hs_c) beat_n_c = pop_c ? 2'd0 : beat + 2'd1;
    end

    // Next beat is selected from the post-edge head so records follow each other without a bubble.
    always_comb begin
        head_c = mem[rd_ptr_n_c];
        data_c = '0;
        case (beat_n_c)
            2'd0:    data_c = head_c[31:0];
            2'd1:    data_c = head_c[63:32];
            2'd2:    data_c = head_c[95:64];
`ifdef TRACE_REG28_EN
            default: data_c = head_c[127:96];
`else
            default: data_c = '0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= rec_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            beat          <= '0;
            fifo_count    <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_ptr_n_c;
            beat       <= beat_n_c;
            fifo_count <= fifo_count + CW'(push_c) - CW'(pop_c);
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            // Only records stored before this edge are presented, giving the one-cycle push-to-beat latency.
            bus.out_valid <= (fifo_count - CW'(pop_c)) != '0;
            bus.out_data  <= data_c;
            bus.out_last  <= (beat_n_c == 2'(NBEATS - 1));
        end
    end
endmodule
